cpu_trace_buffer: RTL and testbench

- Synthesizable on-chip trace capture for the 8-bit CPU. Puts in hardware the cycle-by-cycle trace the simulation bench prints.
- Samples PC, opcode, write address/enable, ALU result, Z/C flags and CU FSM state into a parametrised circular buffer.
- Captures around a programmable PC/opcode trigger, then freezes and drains oldest-first over a valid/request readout handshake.
- Sits beside cpu, tapping CU and DP signals; has no effect on CPU execution.

---
 rtl/cpu_trace_pkg.sv | 49 ++++
 rtl/cpu_trace_buffer_if.sv | 40 ++++
 rtl/trace_ram.sv | 28 ++
 rtl/cpu_trace_buffer.sv | 188 ++++++++++++++++++
 tb/tb_cpu_trace_buffer.sv | 340 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_trace_pkg.sv
// Shared definitions for the CPU trace buffer: FSM encodings and trace entry layout.
// Entry layout, MSB to LSB: {pc, op, wa, we, y, z, c, st}.
package cpu_trace_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_POST  = 2'd2,
        ST_DONE  = 2'd3
    } trc_state_e;

    function automatic int unsigned entry_w(input int unsigned pc_w, input int unsigned op_w,
                                            input int unsigned ra_w, input int unsigned data_w,
                                            input int unsigned st_w);
        return pc_w + op_w + ra_w + 1 + data_w + 2 + st_w;
    endfunction

    // LSB offset of each field; st sits at bit 0.
    function automatic int unsigned off_c(input int unsigned st_w);
        return st_w;
    endfunction

    function automatic int unsigned off_z(input int unsigned st_w);
        return st_w + 1;
    endfunction

    function automatic int unsigned off_y(input int unsigned st_w);
        return st_w + 2;
    endfunction

    function automatic int unsigned off_we(input int unsigned st_w, input int unsigned data_w);
        return st_w + 2 + data_w;
    endfunction

    function automatic int unsigned off_wa(input int unsigned st_w, input int unsigned data_w);
        return st_w + 2 + data_w + 1;
    endfunction

    function automatic int unsigned off_op(input int unsigned st_w, input int unsigned data_w,
                                           input int unsigned ra_w);
        return st_w + 2 + data_w + 1 + ra_w;
    endfunction

    function automatic int unsigned off_pc(input int unsigned st_w, input int unsigned data_w,
                                           input int unsigned ra_w, input int unsigned op_w);
        return st_w + 2 + data_w + 1 + ra_w + op_w;
    endfunction

endpackage

// File: rtl/cpu_trace_buffer_if.sv
// Sample tap and readout handshake between the CPU side and the trace buffer.
interface cpu_trace_buffer_if
    import cpu_trace_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned PC_W   = 8,
    parameter int unsigned OP_W   = 3,
    parameter int unsigned RA_W   = 2,
    parameter int unsigned ST_W   = 3
) ();
    localparam int unsigned E_W = entry_w(PC_W, OP_W, RA_W, DATA_W, ST_W);

    logic              smp_valid;
    logic [PC_W-1:0]   smp_pc;
    logic [OP_W-1:0]   smp_op;
    logic [RA_W-1:0]   smp_wa;
    logic              smp_we;
    logic [DATA_W-1:0] smp_y;
    logic              smp_z;
    logic              smp_c;
    logic [ST_W-1:0]   smp_st;

    logic              rd_req;
    logic              rd_valid;
    logic [E_W-1:0]    rd_data;
    logic              rd_last;

    modport master (
        output smp_valid, smp_pc, smp_op, smp_wa, smp_we, smp_y, smp_z, smp_c, smp_st,
        output rd_req,
        input  rd_valid, rd_data, rd_last
    );

    modport slave (
        input  smp_valid, smp_pc, smp_op, smp_wa, smp_we, smp_y, smp_z, smp_c, smp_st,
        input  rd_req,
        output rd_valid, rd_data, rd_last
    );

endinterface

// File: rtl/trace_ram.sv
// DEPTH x WIDTH simple dual-port RAM with registered read; maps onto block RAM.
module trace_ram #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     re,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
        if (re) begin
            rdata_q <= mem_q[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/cpu_trace_buffer.sv
// On-chip CPU trace capture: circular/single-shot buffer around a PC/opcode trigger,
// frozen on completion and drained oldest-first over a request/valid handshake.
module cpu_trace_buffer
    import cpu_trace_pkg::*;
#(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned PC_W      = 8,
    parameter int unsigned OP_W      = 3,
    parameter int unsigned RA_W      = 2,
    parameter int unsigned ST_W      = 3,
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned POST_TRIG = 8,
    parameter int unsigned TS_W      = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    cpu_trace_buffer_if.slave        bus,
    input  logic                     arm,
    input  logic                     mode,
    input  logic                     trig_pc_en,
    input  logic [PC_W-1:0]          trig_pc,
    input  logic                     trig_op_en,
    input  logic [OP_W-1:0]          trig_op,
    output logic [1:0]               status,
    output logic [$clog2(DEPTH):0]   count,
    output logic [TS_W-1:0]          trig_ts
);
    localparam int unsigned AW  = $clog2(DEPTH);
    localparam int unsigned CW  = AW + 1;
    localparam int unsigned E_W = entry_w(PC_W, OP_W, RA_W, DATA_W, ST_W);

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [AW-1:0] POST_C  = AW'(POST_TRIG);
    localparam logic [AW-1:0] SHOT_C  = AW'(DEPTH - 1);

    trc_state_e      state_q, state_d;
    logic            mode_q, mode_d;
    logic [AW-1:0]   wptr_q, wptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [AW-1:0]   post_cnt_q, post_cnt_d;
    logic [TS_W-1:0] ts_q, ts_d;
    logic [TS_W-1:0] trig_ts_q, trig_ts_d;
    logic [CW-1:0]   rd_cnt_q, rd_cnt_d;
    logic            rd_valid_q, rd_valid_d;
    logic            rd_last_q, rd_last_d;

    logic            hit;
    logic            store;
    logic            ram_we;
    logic            ram_re;
    logic [AW-1:0]   rd_addr;
    logic [TS_W-1:0] ts_inc;
    logic [E_W-1:0]  entry;
    logic [E_W-1:0]  ram_rdata;

    assign entry = {bus.smp_pc, bus.smp_op, bus.smp_wa, bus.smp_we,
                    bus.smp_y, bus.smp_z, bus.smp_c, bus.smp_st};

    assign hit = bus.smp_valid & ((trig_pc_en & (bus.smp_pc == trig_pc)) |
                                  (trig_op_en & (bus.smp_op == trig_op)));

    assign ts_inc = (&ts_q) ? ts_q : ts_q + 1'b1;

    // Oldest entry sits count entries behind wptr; the low bits wrap for free.
    assign rd_addr = wptr_q - count_q[AW-1:0] + rd_cnt_q[AW-1:0];

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        wptr_d     = wptr_q;
        count_d    = count_q;
        post_cnt_d = post_cnt_q;
        ts_d       = ts_q;
        trig_ts_d  = trig_ts_q;
        rd_cnt_d   = rd_cnt_q;
        rd_valid_d = 1'b0;
        rd_last_d  = 1'b0;
        store      = 1'b0;
        ram_re     = 1'b0;

        if (arm) begin
            state_d    = ST_ARMED;
            mode_d     = mode;
            wptr_d     = '0;
            count_d    = '0;
            post_cnt_d = '0;
            ts_d       = '0;
            trig_ts_d  = '0;
            rd_cnt_d   = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                end
                ST_ARMED: begin
                    ts_d = ts_inc;
                    if (!mode_q) begin
                        store = bus.smp_valid;
                        if (hit) begin
                            trig_ts_d  = ts_inc;
                            post_cnt_d = POST_C;
                            state_d    = (POST_TRIG == 0) ? ST_DONE : ST_POST;
                        end
                    end else if (hit) begin
                        store      = 1'b1;
                        trig_ts_d  = ts_inc;
                        post_cnt_d = SHOT_C;
                        state_d    = ST_POST;
                    end
                end
                ST_POST: begin
                    if (bus.smp_valid) begin
                        store      = 1'b1;
                        post_cnt_d = post_cnt_q - 1'b1;
                        if (post_cnt_q == AW'(1)) begin
                            state_d = ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    if (bus.rd_req && (rd_cnt_q != count_q)) begin
                        ram_re     = 1'b1;
                        rd_valid_d = 1'b1;
                        rd_cnt_d   = rd_cnt_q + 1'b1;
                        rd_last_d  = ((rd_cnt_q + 1'b1) == count_q);
                    end
                end
                default: begin
                end
            endcase
        end

        ram_we = store;
        if (store) begin
            wptr_d = wptr_q + 1'b1;
            if (count_q != DEPTH_C) begin
                count_d = count_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            mode_q     <= 1'b0;
            wptr_q     <= '0;
            count_q    <= '0;
            post_cnt_q <= '0;
            ts_q       <= '0;
            trig_ts_q  <= '0;
            rd_cnt_q   <= '0;
            rd_valid_q <= 1'b0;
            rd_last_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            wptr_q     <= wptr_d;
            count_q    <= count_d;
            post_cnt_q <= post_cnt_d;
            ts_q       <= ts_d;
            trig_ts_q  <= trig_ts_d;
            rd_cnt_q   <= rd_cnt_d;
            rd_valid_q <= rd_valid_d;
            rd_last_q  <= rd_last_d;
        end
    end

    trace_ram #(
        .DEPTH (DEPTH),
        .WIDTH (E_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (wptr_q),
        .wdata (entry),
        .re    (ram_re),
        .raddr (rd_addr),
        .rdata (ram_rdata)
    );

    // RAM output register is unreset, so gate it to keep rd_data clean when idle.
    assign bus.rd_data  = rd_valid_q ? ram_rdata : '0;
    assign bus.rd_valid = rd_valid_q;
    assign bus.rd_last  = rd_last_q;
    assign status       = state_q;
    assign count        = count_q;
    assign trig_ts      = trig_ts_q;

endmodule

// File: tb/tb_cpu_trace_buffer.sv
// Randomised bench for cpu_trace_buffer against a queue-based capture model,
// plus directed scenarios with hand-computed expectations.
module tb_cpu_trace_buffer;
    import cpu_trace_pkg::*;

    localparam int unsigned DATA_W    = 8;
    localparam int unsigned PC_W      = 8;
    localparam int unsigned OP_W      = 3;
    localparam int unsigned RA_W      = 2;
    localparam int unsigned ST_W      = 3;
    localparam int unsigned DEPTH     = 8;
    localparam int unsigned POST_TRIG = 3;
    localparam int unsigned TS_W      = 16;
    localparam int unsigned E_W       = entry_w(PC_W, OP_W, RA_W, DATA_W, ST_W);
    localparam int unsigned PC_LSB    = off_pc(ST_W, DATA_W, RA_W, OP_W);
    localparam int unsigned TS_MAX    = (1 << TS_W) - 1;

    typedef logic [E_W-1:0] ent_t;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              arm = 1'b0;
    logic              mode = 1'b0;
    logic              trig_pc_en = 1'b0;
    logic [PC_W-1:0]   trig_pc = '0;
    logic              trig_op_en = 1'b0;
    logic [OP_W-1:0]   trig_op = '0;
    logic [1:0]        status;
    logic [3:0]        count;
    logic [TS_W-1:0]   trig_ts;

    cpu_trace_buffer_if #(
        .DATA_W (DATA_W), .PC_W (PC_W), .OP_W (OP_W), .RA_W (RA_W), .ST_W (ST_W)
    ) bus ();

    cpu_trace_buffer #(
        .DATA_W (DATA_W), .PC_W (PC_W), .OP_W (OP_W), .RA_W (RA_W), .ST_W (ST_W),
        .DEPTH (DEPTH), .POST_TRIG (POST_TRIG), .TS_W (TS_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .arm        (arm),
        .mode       (mode),
        .trig_pc_en (trig_pc_en),
        .trig_pc    (trig_pc),
        .trig_op_en (trig_op_en),
        .trig_op    (trig_op),
        .status     (status),
        .count      (count),
        .trig_ts    (trig_ts)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: the stored history is a queue holding at most DEPTH newest samples.
    ent_t        m_buf[$];
    int          m_phase = 0;
    bit          m_mode = 1'b0;
    int          m_post = 0;
    int unsigned m_ts = 0;
    int unsigned m_trig = 0;
    int          m_nread = 0;
    bit          m_rdv = 1'b0;
    bit          m_last = 1'b0;
    ent_t        m_data = '0;
    ent_t        m_e;
    bit          m_hit;

    function automatic void push(input ent_t e);
        m_buf.push_back(e);
        if (m_buf.size() > DEPTH) void'(m_buf.pop_front());
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_buf.delete();
            m_phase = 0;
            m_ts    = 0;
            m_trig  = 0;
            m_nread = 0;
            m_rdv   = 1'b0;
            m_last  = 1'b0;
        end else begin
            m_e = {bus.smp_pc, bus.smp_op, bus.smp_wa, bus.smp_we,
                   bus.smp_y, bus.smp_z, bus.smp_c, bus.smp_st};
            m_hit = bus.smp_valid && ((trig_pc_en && bus.smp_pc == trig_pc) ||
                                      (trig_op_en && bus.smp_op == trig_op));
            m_rdv  = 1'b0;
            m_last = 1'b0;
            if (arm) begin
                m_phase = 1;
                m_mode  = mode;
                m_buf.delete();
                m_ts    = 0;
                m_trig  = 0;
                m_nread = 0;
            end else begin
                case (m_phase)
                    1: begin
                        if (m_ts < TS_MAX) m_ts++;
                        if (!m_mode) begin
                            if (bus.smp_valid) push(m_e);
                            if (m_hit) begin
                                m_trig = m_ts;
                                if (POST_TRIG == 0) m_phase = 3;
                                else begin
                                    m_phase = 2;
                                    m_post  = POST_TRIG;
                                end
                            end
                        end else if (m_hit) begin
                            push(m_e);
                            m_trig  = m_ts;
                            m_post  = DEPTH - 1;
                            m_phase = 2;
                        end
                    end
                    2: begin
                        if (bus.smp_valid) begin
                            push(m_e);
                            m_post--;
                            if (m_post == 0) m_phase = 3;
                        end
                    end
                    3: begin
                        if (bus.rd_req && m_nread < m_buf.size()) begin
                            m_rdv  = 1'b1;
                            m_data = m_buf[m_nread];
                            m_nread++;
                            m_last = (m_nread == m_buf.size());
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always @(negedge clk) begin
        chk("status", status, m_phase);
        chk("count", count, m_buf.size());
        chk("rd_valid", bus.rd_valid, m_rdv);
        if (m_rdv) begin
            chk("rd_data", bus.rd_data, m_data);
            chk("rd_last", bus.rd_last, m_last);
        end
        if (m_phase == 3) chk("trig_ts", trig_ts, m_trig);
    end

    int rd_pcs[$];
    int last_pc;

    function automatic int pc_of(input ent_t d);
        return int'(d[PC_LSB +: PC_W]);
    endfunction

    // vmode: 0 every cycle valid, 1 valid on even cycles only, 2 random ~75%.
    task automatic capture(input bit md, input bit pen, input int tpc, input bit oen, input int top,
                           input int first_op, input int vmode, input bit do_arm, input int target);
        bit done;
        bit v;
        int op;
        trig_pc_en = pen;
        trig_pc    = PC_W'(tpc);
        trig_op_en = oen;
        trig_op    = OP_W'(top);
        if (do_arm) begin
            mode = md;
            arm  = 1'b1;
            bus.smp_valid = 1'b0;
            @(negedge clk);
            arm = 1'b0;
        end
        done = 1'b0;
        for (int i = 0; i < 150 && !done; i++) begin
            if (vmode == 0) v = 1'b1;
            else if (vmode == 1) v = (i % 2 == 0);
            else v = ($urandom_range(0, 3) != 0);
            if (pen && i == tpc) v = 1'b1;
            op = $urandom_range(0, 7);
            if (oen && i < first_op) op = (top + 1 + $urandom_range(0, 6)) % 8;
            if (oen && i == first_op) begin
                op = top;
                v  = 1'b1;
            end
            bus.smp_valid = v;
            bus.smp_pc    = PC_W'(i);
            bus.smp_op    = OP_W'(op);
            bus.smp_wa    = RA_W'($urandom);
            bus.smp_we    = 1'($urandom);
            bus.smp_y     = DATA_W'($urandom);
            bus.smp_z     = 1'($urandom);
            bus.smp_c     = 1'($urandom);
            bus.smp_st    = ST_W'($urandom);
            @(negedge clk);
            if (status == 2'(target)) done = 1'b1;
        end
        bus.smp_valid = 1'b0;
        chk("capture_state", status, target);
    endtask

    task automatic read_out(input bit b2b, input int max_n, input int extra);
        bit stop;
        stop = 1'b0;
        rd_pcs.delete();
        last_pc = -1;
        for (int k = 0; k < 80 && !stop; k++) begin
            bus.rd_req = b2b ? 1'b1 : ($urandom_range(0, 2) != 0);
            @(negedge clk);
            if (bus.rd_valid) begin
                rd_pcs.push_back(pc_of(bus.rd_data));
                if (bus.rd_last) begin
                    last_pc = pc_of(bus.rd_data);
                    stop = 1'b1;
                end
            end
            if (rd_pcs.size() >= max_n) stop = 1'b1;
        end
        bus.rd_req = 1'b0;
        for (int k = 0; k < extra; k++) begin
            bus.rd_req = 1'b1;
            @(negedge clk);
            chk("rd_after_last", bus.rd_valid, 0);
        end
        bus.rd_req = 1'b0;
    endtask

    task automatic check_seq(input string nm, input int first, input int step, input int n);
        chk({nm, "_n"}, rd_pcs.size(), n);
        for (int k = 0; k < rd_pcs.size(); k++) chk({nm, "_pc"}, rd_pcs[k], first + step * k);
        chk({nm, "_last"}, last_pc, first + step * (n - 1));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.smp_valid = 1'b0;
        bus.smp_pc = '0; bus.smp_op = '0; bus.smp_wa = '0; bus.smp_we = 1'b0;
        bus.smp_y = '0; bus.smp_z = 1'b0; bus.smp_c = 1'b0; bus.smp_st = '0;
        bus.rd_req = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_status", status, 0);
        chk("rst_count", count, 0);
        chk("rst_rd_valid", bus.rd_valid, 0);
        chk("rst_rd_data", bus.rd_data, 0);
        chk("rst_rd_last", bus.rd_last, 0);
        chk("rst_trig_ts", trig_ts, 0);
        reset = 1'b0;
        @(negedge clk);

        // Circular, trigger at pc 10.
        capture(1'b0, 1'b1, 10, 1'b0, 0, 0, 0, 1'b1, 3);
        chk("t1_count", count, 8);
        chk("t1_trig_ts", trig_ts, 11);
        read_out(1'b1, DEPTH, 1);
        check_seq("t1", 6, 1, 8);

        // Circular, early trigger at pc 1, gapped requests.
        capture(1'b0, 1'b1, 1, 1'b0, 0, 0, 0, 1'b1, 3);
        chk("t2_count", count, 5);
        read_out(1'b0, DEPTH, 1);
        check_seq("t2", 0, 1, 5);

        // Single-shot, opcode 5 first seen at pc 4.
        capture(1'b1, 1'b0, 0, 1'b1, 5, 4, 0, 1'b1, 3);
        chk("t3_count", count, 8);
        read_out(1'b1, DEPTH, 1);
        check_seq("t3", 4, 1, 8);

        // Valid only on even cycles.
        capture(1'b0, 1'b1, 10, 1'b0, 0, 0, 1, 1'b1, 3);
        chk("t4_count", count, 8);
        read_out(1'b1, DEPTH, 1);
        check_seq("t4", 2, 2, 8);

        // Reset asserted during POST.
        capture(1'b0, 1'b1, 10, 1'b0, 0, 0, 0, 1'b1, 2);
        #2 reset = 1'b1;
        @(negedge clk);
        chk("t5_status", status, 0);
        chk("t5_count", count, 0);
        chk("t5_rd_valid", bus.rd_valid, 0);
        reset = 1'b0;
        bus.rd_req = 1'b1;
        @(negedge clk);
        bus.rd_req = 1'b0;
        chk("t5_rd_after_reset", bus.rd_valid, 0);

        // Re-arm in DONE part-way through readout.
        capture(1'b0, 1'b1, 10, 1'b0, 0, 0, 0, 1'b1, 3);
        read_out(1'b1, 3, 0);
        chk("t6_partial_n", rd_pcs.size(), 3);
        chk("t6_partial_first", rd_pcs[0], 6);
        mode = 1'b0;
        arm = 1'b1;
        bus.rd_req = 1'b1;
        @(negedge clk);
        arm = 1'b0;
        bus.rd_req = 1'b0;
        chk("t6_status", status, 1);
        chk("t6_count", count, 0);
        chk("t6_rd_valid", bus.rd_valid, 0);
        capture(1'b0, 1'b1, 10, 1'b0, 0, 0, 0, 1'b0, 3);
        chk("t6_count_done", count, 8);
        chk("t6_trig_ts", trig_ts, 11);
        read_out(1'b1, DEPTH, 1);
        check_seq("t6", 6, 1, 8);

        // Random captures checked by the model.
        repeat (6) begin
            capture(1'($urandom_range(0, 1)), 1'b1, $urandom_range(0, 20), 1'b0, 0, 0, 2, 1'b1, 3);
            read_out(1'($urandom_range(0, 1)), DEPTH, 2);
        end
        capture(1'b1, 1'b0, 0, 1'b1, 6, 5, 2, 1'b1, 3);
        read_out(1'b0, DEPTH, 2);
        capture(1'b0, 1'b0, 0, 1'b1, 2, 9, 2, 1'b1, 3);
        read_out(1'b1, DEPTH, 2);

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
